pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) driven by the main
//  decoder's Branch/MemRead/MemWrite flags. Detects load-use hazards, flushes on
//  taken BEQ resolved in MEM, and freezes the pipe while a multi-cycle data memory
//  completes a req/ready handshake. Also keeps saturating stall/flush counters.
// PARAMETERS
//  REG_AW       5   register address width
//  CNT_W        16  width of perf counters
//  MEM_TIMEOUT  15  max MEM_WAIT cycles before mem_error; 0 = no timeout
// PORTS
//  clk          in   1      pipeline clock
//  reset        in   1      synchronous, active-high
//  id_rs        in   REG_AW rs field of instruction in ID
//  id_rt        in   REG_AW rt field of instruction in ID
//  id_uses_rt   in   1      ID instruction reads rt (R-type, SW, BEQ)
//  ex_memread   in   1      MemRead of instruction in EX (ID/EX reg)
//  ex_rt        in   REG_AW destination rt of instruction in EX
//  mem_memread  in   1      MemRead of instruction in MEM (EX/MEM reg)
//  mem_memwrite in   1      MemWrite of instruction in MEM
//  mem_branch   in   1      Branch of instruction in MEM
//  mem_zero     in   1      ALU zero of instruction in MEM
//  dmem_ready   in   1      data memory completes access this cycle
//  dmem_req     out  1      data memory access request
//  pc_write     out  1      PC load enable
//  ifid_write   out  1      IF/ID load enable
//  idex_write   out  1      ID/EX load enable
//  exmem_write  out  1      EX/MEM and MEM/WB load enable
//  pc_src       out  1      1 = load branch target into PC
//  ifid_flush   out  1      clear IF/ID to NOP
//  idex_flush   out  1      clear ID/EX controls (bubble)
//  exmem_flush  out  1      clear EX/MEM controls
//  mem_error    out  1      sticky: MEM_TIMEOUT expired
//  stall_cnt    out  CNT_W  cycles with pc_write=0 (saturating)
//  flush_cnt    out  CNT_W  taken branches (saturating)
// BEHAVIOUR
//  FSM states RUN, MEM_WAIT; reset -> RUN, counters 0, mem_error 0, wait_cnt 0.
//  While reset=1: all *_write=0, all *_flush=1, dmem_req=0, pc_src=0.
//  Control outputs are combinational from state+inputs; counters/flags registered.
//  mem_op = mem_memread | mem_memwrite.
//  RUN, mem_op & !dmem_ready: dmem_req=1, all *_write=0, -> MEM_WAIT, wait_cnt=0.
//  RUN, mem_op & dmem_ready: dmem_req=1, zero-latency access, pipe advances.
//  MEM_WAIT: dmem_req=1, all *_write=0, no flush; wait_cnt++. dmem_ready -> RUN
//   with all *_write=1 that cycle. If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT-1
//   without ready: mem_error<=1, -> RUN, access treated as done (writes=1).
//  Taken branch (mem_branch & mem_zero, pipe not frozen): pc_src=1; ifid_flush,
//   idex_flush, exmem_flush=1 for exactly one cycle; all *_write=1; flush_cnt++.
//  Load-use (ex_memread & ex_rt!=0 & (ex_rt==id_rs | id_uses_rt & ex_rt==id_rt)):
//   pc_write=0, ifid_write=0, idex_flush=1; EX/MEM advances; 1 bubble per hazard.
//  Priority: memory freeze > branch flush > load-use. Branch and load-use same
//   cycle: flush only, no stall, stall_cnt unchanged.
//  mem_op & branch in same MEM slot: memory completes first, then flush evaluated.
//  stall_cnt++ every cycle pc_write=0 outside reset; both counters saturate at
//   all-ones, never wrap. mem_error cleared only by reset.
//  Reset asserted in MEM_WAIT: next cycle RUN, dmem_req=0, wait_cnt=0.
// STRUCTURE
//  pipeline_pkg: FSM state encoding, opcodes (R 000000, LW 100011, SW 101011,
//   BEQ 000100), REG_AW default, ALUOp encodings shared with main decoder.
//  Sub-module sat_counter (CNT_W, inc, clk, reset) instanced for stall/flush cnt.
// TESTING
//  LW $2 in EX, ADD reads $2 in ID -> 1 cycle pc_write=0, idex_flush=1, stall_cnt=1.
//  LW $0 in EX, ID reads $0 -> no stall, pc_write=1 throughout.
//  BEQ taken in MEM -> pc_src=1, 3 flushes high 1 cycle, flush_cnt=1.
//  SW in MEM, dmem_ready low 4 cycles -> all writes 0 for 4 cycles, dmem_req held 5.
//  MEM_TIMEOUT=3, ready never -> mem_error=1 after 3 wait cycles, state RUN.
//  Reset pulsed during MEM_WAIT -> dmem_req=0 next cycle, counters 0, RUN.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: sequencer states, main
// decoder opcodes and ALUOp encodings, and default widths.
package pipeline_pkg;

    localparam int DEF_REG_AW      = 5;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_MEM_TIMEOUT = 15;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    typedef enum logic [5:0] {
        OP_R   = 6'b000000,
        OP_LW  = 6'b100011,
        OP_SW  = 6'b101011,
        OP_BEQ = 6'b000100
    } opcode_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the IF/ID/EX/MEM/WB pipe: memory freeze, taken-branch
// flush, load-use bubble, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_AW      = DEF_REG_AW,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              mem_memread,
    input  logic              mem_memwrite,
    input  logic              mem_branch,
    input  logic              mem_zero,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_write,
    output logic              exmem_write,
    output logic              pc_src,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              mem_error,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              dbg_state
);

    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = (MEM_TIMEOUT == 0) ? '0 : WW'(MEM_TIMEOUT - 1);

    hz_state_t     state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_cnt_nxt;
    logic          mem_op;
    logic          taken;
    logic          load_use;
    logic          timeout_hit;
    logic          frozen;
    logic          set_error;
    logic          stall_inc;
    logic          flush_inc;

    assign mem_op   = mem_memread | mem_memwrite;
    assign taken    = mem_branch & mem_zero;
    assign load_use = ex_memread & (ex_rt != '0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    assign timeout_hit = (MEM_TIMEOUT != 0) && (state == ST_MEM_WAIT) &&
                         !dmem_ready && (wait_cnt == WAIT_LAST);

    assign dbg_state = (state == ST_MEM_WAIT);

    // Handshake: dmem_req stays high from the first cycle the access is in MEM
    // until the cycle dmem_ready is seen (or the wait times out); the access
    // completes in the cycle where req and ready are both high, and the pipe
    // advances in that same cycle.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        frozen       = 1'b0;
        set_error    = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_op && !dmem_ready) begin
                    frozen       = 1'b1;
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt = ST_RUN;
                end else if (timeout_hit) begin
                    set_error = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    frozen       = 1'b1;
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Priority: reset, memory freeze, branch flush, load-use bubble.
    always_comb begin
        dmem_req    = mem_op | (state == ST_MEM_WAIT);
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        pc_src      = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (reset) begin
            dmem_req    = 1'b0;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (frozen) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (taken) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX, let EX/MEM drain.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_error <= mem_error | set_error;
        end
    end

    assign stall_inc = !reset && !pc_write;
    assign flush_inc = !reset && pc_src;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule
